student_pc_n: RTL and testbench

Parametrised N-bit program-counter/register block: the sequential successor to the combinational 16-bit incrementer. It holds a count that can be cleared, loaded, incremented or decremented by a programmable step, with selectable wrap or saturate behaviour and overflow reporting. It sits in the CPU datapath as the PC and serves as a general-purpose loop counter.

---
 rtl/student_pc_pkg.sv | 22 ++
 rtl/student_addn.sv | 30 +++
 rtl/student_pc_n.sv | 112 +++++++++++
 tb/tb_student_pc_n.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/student_pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : student_pc_pkg
// Description : Shared command encoding and saturation-mode constants.
// Revision    : 1.0
// ============================================================================
package student_pc_pkg;

   // Listed in decode priority order, highest first.
   typedef enum logic [2:0] {
      CMD_CLR  = 3'd0,
      CMD_LOAD = 3'd1,
      CMD_INC  = 3'd2,
      CMD_DEC  = 3'd3,
      CMD_HOLD = 3'd4
   } cmd_e;

   localparam logic SAT_MODE  = 1'b1;
   localparam logic WRAP_MODE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/student_addn.sv
`default_nettype none
// ============================================================================
// Module      : student_addn
// Description : WIDTH+1-bit add/subtract of a zero-extended step, with carry.
// Revision    : 1.0
// ============================================================================
module student_addn #(
   parameter int WIDTH  = 16,
   parameter int STEP_W = 4
) (
   input  logic [WIDTH-1:0]  a_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              sub_i,
   output logic [WIDTH-1:0]  res_o,
   output logic              cout_o
);

   logic [WIDTH:0] a_ext;
   logic [WIDTH:0] step_ext;
   logic [WIDTH:0] result;

   assign a_ext    = {1'b0, a_i};
   assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
   // Bit WIDTH is carry when adding and borrow when subtracting.
   assign result   = sub_i ? (a_ext - step_ext) : (a_ext + step_ext);
   assign res_o    = result[WIDTH-1:0];
   assign cout_o   = result[WIDTH];

endmodule
`default_nettype wire

// File: rtl/student_pc_n.sv
`default_nettype none
// ============================================================================
// Module      : student_pc_n
// Description : N-bit program counter with clear/load/step up/down,
//               wrap or saturate, wrap pulse and sticky overflow.
// Revision    : 1.0
// ============================================================================
module student_pc_n
   import student_pc_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter int               STEP_W    = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic [WIDTH-1:0]  din,
   input  logic              inc,
   input  logic              dec,
   input  logic [STEP_W-1:0] step,
   input  logic              sat,
   output logic [WIDTH-1:0]  out,
   output logic              wrap,
   output logic              ovf
);

   cmd_e             cmd;
   logic [WIDTH-1:0] out_q, out_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             step_nz;

   assign step_nz = (step != '0);

   always_comb begin
      cmd = CMD_HOLD;
      if (clr) begin
         cmd = CMD_CLR;
      end else if (load) begin
         cmd = CMD_LOAD;
      end else if (inc && !dec && step_nz) begin
         cmd = CMD_INC;
      end else if (dec && !inc && step_nz) begin
         cmd = CMD_DEC;
      end
   end

   student_addn #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_addn (
      .a_i    (out_q),
      .step_i (step),
      .sub_i  (cmd == CMD_DEC),
      .res_o  (sum),
      .cout_o (carry)
   );

   always_comb begin
      out_d  = out_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q;
      case (cmd)
         CMD_CLR: begin
            out_d = '0;
            ovf_d = 1'b0;
         end
         CMD_LOAD: begin
            out_d = din;
         end
         CMD_INC, CMD_DEC: begin
            if (carry) begin
               ovf_d = 1'b1;
               case (sat)
                  SAT_MODE:  out_d = (cmd == CMD_INC) ? '1 : '0;
                  WRAP_MODE: begin
                     out_d  = sum;
                     wrap_d = 1'b1;
                  end
               endcase
            end else begin
               out_d = sum;
            end
         end
         default: begin
            out_d = out_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= RESET_VAL;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

   assign out  = out_q;
   assign wrap = wrap_q;
   assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_student_pc_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_student_pc_n
// Description : Randomised scoreboard bench for student_pc_n (16-bit, step 4).
// Revision    : 1.0
// ============================================================================
module tb_student_pc_n;

   localparam int MAXV = 65535;

   typedef struct {
      logic [15:0] out;
      logic        wrap;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clr = 1'b0;
   logic        load = 1'b0;
   logic [15:0] din = 16'h0;
   logic        inc = 1'b0;
   logic        dec = 1'b0;
   logic [3:0]  step = 4'h0;
   logic        sat = 1'b0;
   logic [15:0] out;
   logic        wrap;
   logic        ovf;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_cnt = 0;
   bit   m_ovf = 1'b0;
   bit   m_wrap = 1'b0;

   student_pc_n #(
      .WIDTH     (16),
      .STEP_W    (4),
      .RESET_VAL (16'h0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .load  (load),
      .din   (din),
      .inc   (inc),
      .dec   (dec),
      .step  (step),
      .sat   (sat),
      .out   (out),
      .wrap  (wrap),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: every edge that follows an issued command presents a result.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("out",  out,           e.out);
         chk("wrap", {15'h0, wrap}, {15'h0, e.wrap});
         chk("ovf",  {15'h0, ovf},  {15'h0, e.ovf});
      end
   end

   task automatic issue(input logic c, input logic l, input logic [15:0] d,
                        input logic i, input logic dc, input logic [3:0] s,
                        input logic st);
      int   nv;
      exp_t e;
      @(negedge clk);
      clr = c; load = l; din = d; inc = i; dec = dc; step = s; sat = st;
      m_wrap = 1'b0;
      if (c) begin
         m_cnt = 0;
         m_ovf = 1'b0;
      end else if (l) begin
         m_cnt = int'(d);
      end else if ((i != dc) && (s != 0)) begin
         nv = i ? (m_cnt + int'(s)) : (m_cnt - int'(s));
         if (nv > MAXV || nv < 0) begin
            m_ovf = 1'b1;
            if (st) begin
               m_cnt = (nv > MAXV) ? MAXV : 0;
            end else begin
               m_cnt  = (nv + MAXV + 1) % (MAXV + 1);
               m_wrap = 1'b1;
            end
         end else begin
            m_cnt = nv;
         end
      end
      e.out  = m_cnt[15:0];
      e.wrap = m_wrap;
      e.ovf  = m_ovf;
      exp_q.push_back(e);
   endtask

   // Reset asserted between edges must take effect without any clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      clr = 0; load = 0; inc = 0; dec = 0; step = 0; sat = 0;
      rst_n = 1'b0;
      #1;
      chk("rst_out",  out,           16'h0000);
      chk("rst_wrap", {15'h0, wrap}, 16'h0000);
      chk("rst_ovf",  {15'h0, ovf},  16'h0000);
      m_cnt = 0;
      m_ovf = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_hold_out", out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      do_reset();
      repeat (3) issue(0, 0, 16'h0, 1, 0, 4'd1, 0);
      // Wrap up, then continue with sticky ovf.
      issue(0, 1, 16'hFFFF, 0, 0, 4'd0, 0);
      issue(0, 0, 16'h0, 1, 0, 4'd1, 0);
      issue(0, 0, 16'h0, 1, 0, 4'd1, 0);
      // Saturate up and down.
      issue(0, 1, 16'hFFFE, 0, 0, 4'd0, 0);
      issue(0, 0, 16'h0, 1, 0, 4'd5, 1);
      issue(0, 1, 16'h0003, 0, 0, 4'd0, 0);
      issue(0, 0, 16'h0, 0, 1, 4'd5, 1);
      // Wrap down.
      issue(0, 1, 16'h0003, 0, 0, 4'd0, 0);
      issue(0, 0, 16'h0, 0, 1, 4'd5, 0);
      // Priority and hold cases.
      issue(1, 1, 16'h1234, 1, 0, 4'd1, 0);
      issue(0, 1, 16'h1234, 1, 0, 4'd1, 0);
      issue(0, 0, 16'h0, 1, 1, 4'd3, 0);
      issue(0, 0, 16'h0, 1, 0, 4'd0, 0);
      issue(0, 0, 16'h0, 0, 1, 4'd0, 1);
      // Reset mid-count, then resume from zero.
      issue(0, 1, 16'h0010, 0, 0, 4'd0, 0);
      repeat (4) issue(0, 0, 16'h0, 1, 0, 4'd15, 0);
      do_reset();
      repeat (2) issue(0, 0, 16'h0, 1, 0, 4'd1, 0);

      for (int k = 0; k < 1500; k++) begin
         int r;
         r = $urandom_range(0, 199);
         if (r < 3) begin
            do_reset();
         end else begin
            case ($urandom_range(0, 4))
               0:       d = 16'hFFFF;
               1:       d = 16'hFFF0 | 16'($urandom_range(0, 15));
               2:       d = 16'($urandom_range(0, 15));
               default: d = 16'($urandom);
            endcase
            issue(r < 8, $urandom_range(0, 7) == 0, d,
                  1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
         end
      end

      @(negedge clk);
      clr = 0; load = 0; inc = 0; dec = 0;
      repeat (2) @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
